// File: rtl/crg_run_sequencer_if.sv
// Port bundles for crg_run_sequencer: host side (UART controller) and core side (CRG core).
// master drives the request, slave answers; the sequencer is slave on host and master on core.
interface crg_host_if #(
   parameter int LEN_DIN  = 256,
   parameter int LEN_DOUT = 768,
   parameter int CNT_W    = 21
);
   logic                run;
   logic [LEN_DIN-1:0]  extin_data;
   logic [LEN_DOUT-1:0] extout_data;
   logic                busy;
   logic                err_timeout;
   logic                overrun;
   logic [CNT_W-1:0]    cycles_last;
   logic [3:0]          led;

   modport master (
      output run, extin_data,
      input  extout_data, busy, err_timeout, overrun, cycles_last, led
   );
   modport slave (
      input  run, extin_data,
      output extout_data, busy, err_timeout, overrun, cycles_last, led
   );
endinterface

interface crg_core_if #(
   parameter int LEN_DIN  = 256,
   parameter int LEN_DOUT = 768
);
   logic                core_start;
   logic [LEN_DIN-1:0]  core_din;
   logic                core_done;
   logic [LEN_DOUT-1:0] core_dout;

   modport master (
      output core_start, core_din,
      input  core_done, core_dout
   );
   modport slave (
      input  core_start, core_din,
      output core_done, core_dout
   );
endinterface

// File: rtl/crg_run_sequencer.sv
// Sequences one CRG run: latch host input, launch core, wait for done with timeout, capture result.
// Optional macro CRG_SEQ_CYCLE_COUNT_EN enables the cycles_last capture register.
//
// state   | meaning
// IDLE    | waiting for run; clears sticky flags on accept
// LATCH   | core_din <= extin_data
// START   | core_start high, counter cleared
// WAIT    | counting; done -> CAPTURE, counter at TIMEOUT-1 -> IDLE with err_timeout
// CAPTURE | extout_data <= registered result, toggle done_toggle
module crg_run_sequencer #(
   parameter int LEN_DIN  = 256,
   parameter int LEN_DOUT = 768,
   parameter int TIMEOUT  = 1048576,
   parameter int CNT_W    = 21
) (
   input  logic       clk,
   input  logic       rst_n,
   crg_host_if.slave  host,
   crg_core_if.master core
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_START,
      S_WAIT,
      S_CAPTURE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

   state_t              state;
   state_t              state_nx;
   logic [CNT_W-1:0]    counter;
   logic                cnt_tc;
   logic                launch;
   logic                done_hit;
   logic                timeout_hit;
   logic [LEN_DIN-1:0]  din_q;
   logic [LEN_DOUT-1:0] dout_q;
   logic [LEN_DOUT-1:0] ext_q;
   logic                core_start_q;
   logic                done_toggle;
   logic                err_q;
   logic                ovr_q;

   assign cnt_tc      = (counter == CNT_TC);
   assign launch      = (state == S_IDLE) && host.run;
   assign done_hit    = (state == S_WAIT) && core.core_done;
   assign timeout_hit = (state == S_WAIT) && !core.core_done && cnt_tc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (host.run) state_nx = S_LATCH;
         S_LATCH:   state_nx = S_START;
         S_START:   state_nx = S_WAIT;
         S_WAIT: begin
            if (core.core_done) state_nx = S_CAPTURE;
            else if (cnt_tc)    state_nx = S_IDLE;
         end
         S_CAPTURE: state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // core_start is decoded one state early so it leaves a flop, glitch-free, during START
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_start_q <= 1'b0;
         din_q        <= '0;
         counter      <= '0;
         dout_q       <= '0;
         ext_q        <= '0;
         done_toggle  <= 1'b0;
         err_q        <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         core_start_q <= (state == S_LATCH);
         if (state == S_LATCH) din_q <= host.extin_data;
         if (state == S_START) counter <= '0;
         else if (state == S_WAIT && !cnt_tc) counter <= counter + CNT_W'(1);
         if (done_hit) dout_q <= core.core_dout;
         if (state == S_CAPTURE) begin
            ext_q       <= dout_q;
            done_toggle <= ~done_toggle;
         end
         if (launch)           err_q <= 1'b0;
         else if (timeout_hit) err_q <= 1'b1;
         if (launch)                              ovr_q <= 1'b0;
         else if (state != S_IDLE && host.run)    ovr_q <= 1'b1;
      end
   end

`ifdef CRG_SEQ_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cyc_q;

   // counter already includes the done cycle; +1 adds the START cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cyc_q <= '0;
      else if (state == S_CAPTURE) cyc_q <= counter + CNT_W'(1);
   end
   assign host.cycles_last = cyc_q;
`else
   assign host.cycles_last = '0;
`endif

   assign core.core_start  = core_start_q;
   assign core.core_din    = din_q;
   assign host.extout_data = ext_q;
   assign host.busy        = (state != S_IDLE);
   assign host.err_timeout = err_q;
   assign host.overrun     = ovr_q;
   assign host.led         = {done_toggle, ovr_q, err_q, (state != S_IDLE)};

endmodule

// File: doc/crg_run_sequencer.md
Name: crg_run_sequencer

Overview:
Sequences one correlated-random-generation run between the UART control block and the CRG core. On a `run` pulse from the UART side it latches the 256-bit host input and launches the core. It then waits for the core's done strobe, bounded by a timeout, and captures the 768-bit core output into a stable readback register. It also drives the four board LEDs with busy, error and completion status.

Parameters:
- LEN_DIN, 256, width of the host input word and of the core input.
- LEN_DOUT, 768, width of the core output and of the readback word.
- TIMEOUT, 1048576, maximum number of cycles spent in WAIT before aborting.
- CNT_W, 21, width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  single-cycle start pulse from the UART controller.
- extin_data  in  LEN_DIN  host input word from the UART controller.
- core_start  out  1  one-cycle launch pulse to the CRG core.
- core_din  out  LEN_DIN  registered input to the core; held stable from START until the next LATCH.
- core_done  in  1  one-cycle completion strobe from the core.
- core_dout  in  LEN_DOUT  core result; valid in the cycle core_done is high.
- extout_data  out  LEN_DOUT  captured result, readable by the UART controller.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky flag: the last run timed out.
- overrun  out  1  sticky flag: a run pulse arrived while busy.
- cycles_last  out  CNT_W  cycle count of the last completed run (see Optional Feature).
- led  out  4  board LEDs: {done_toggle, overrun, err_timeout, busy}.

Behaviour:
Reset (asynchronous, rst_n=0):
- State goes to IDLE.
- All outputs go to 0: core_din, extout_data, core_start, flags, counter, done_toggle and cycles_last.

States and transitions:
- IDLE: when run=1, go to LATCH. Clear err_timeout and overrun.
- LATCH: core_din <= extin_data. Go to START.
- START: core_start=1 for exactly this cycle. Counter <= 0. Go to WAIT.
- WAIT: counter increments every cycle.
  - If core_done=1, go to CAPTURE and register core_dout this cycle.
  - Else if counter == TIMEOUT-1, set err_timeout and go to IDLE; extout_data is left unchanged.
  - If core_done and the timeout condition occur in the same cycle, done wins.
- CAPTURE: extout_data <= the value registered in WAIT. Toggle done_toggle. Go to IDLE.

Latency:
- From run to core_start: 2 cycles (run seen in cycle n, core_start high in cycle n+2).
- From core_done to the extout_data update: 2 cycles.

Boundary conditions:
- run while busy is ignored: the run in progress is unaffected, and overrun is set.
- run in the same cycle that CAPTURE or a timeout returns the FSM to IDLE is also ignored and sets overrun.
- core_done outside WAIT is ignored, including a done in the START cycle.
- extout_data only changes in CAPTURE and is otherwise held, including across timeouts.
- Counter saturates at TIMEOUT-1 and does not wrap.
- rst_n asserted mid-run aborts immediately. No core_start glitch: core_start is a registered output.

Optional Feature:
Macro: CRG_SEQ_CYCLE_COUNT_EN.
- Defined: in CAPTURE, cycles_last <= counter+1, i.e. the number of cycles from START to core_done inclusive. A timeout leaves cycles_last unchanged.
- Undefined: cycles_last is tied to 0 and no capture register is synthesised.

Test Plan:
1. Normal run: extin_data=256'h1234, run pulse, core model asserts core_done 10 cycles after core_start with core_dout=768'hABCD.
   - Required: core_start exactly 2 cycles after run; core_din=256'h1234; extout_data=768'hABCD exactly 2 cycles after done; busy returns to 0; led[3] toggles.
   - Required with the macro: cycles_last=11.
2. Timeout: TIMEOUT=16, core never asserts done.
   - Required: err_timeout=1 and back in IDLE 16 cycles after entering WAIT; extout_data keeps its previous value.
   - Required on the next run: err_timeout clears.
3. Overrun: second run pulse 3 cycles after the first.
   - Required: only one core_start; overrun=1; the first run completes normally.
   - Required on the next run from IDLE: overrun clears.
4. Simultaneous events, TIMEOUT=16:
   - core_done in the same cycle counter=15 -> CAPTURE taken, err_timeout=0.
   - core_done in the START cycle -> ignored; FSM stays in WAIT.
5. Reset mid-WAIT: rst_n pulled low for 1 cycle -> all outputs read 0 immediately; FSM in IDLE; a subsequent run starts cleanly.
6. Back-to-back runs: run pulsed the cycle after busy falls -> second launch accepted; extout_data updated twice; led[3] returns to its original level.
